// File: rtl/branch_predictor_bht_pkg.sv
// Shared definitions for the branch history table: 2-bit counter encodings,
// the table reset value and PC-to-index extraction.
package branch_predictor_bht_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam logic [1:0] BHT_INIT = WNT;

   localparam int MAX_INDEX_BITS = 16;

   // PCs are word aligned, so the index starts at bit 2; upper bits alias freely.
   function automatic logic [MAX_INDEX_BITS-1:0] bht_index(input logic [63:0] pc,
                                                           input int unsigned index_bits);
      logic [63:0] mask;
      mask = (64'd1 << index_bits) - 64'd1;
      return MAX_INDEX_BITS'((pc >> 2) & mask);
   endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter2.sv
// Single 2-bit saturating counter, resets to weakly not-taken.
// Updates on the clock edge after inc_i/dec_i; inc_i wins if both are high.
module sat_counter2
   import branch_predictor_bht_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [1:0] cnt_o
);

   logic [1:0] cnt_q;
   logic [1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i) begin
         if (cnt_q != ST) cnt_d = cnt_q + 2'd1;
      end else if (dec_i) begin
         if (cnt_q != SNT) cnt_d = cnt_q - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= BHT_INIT;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor_bht.sv
// 2-bit saturating-counter BHT: zero-latency lookup for the fetch PC, training
// from resolved EXE branches, plus saturating branch/mispredict statistics.
module branch_predictor_bht
   import branch_predictor_bht_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_fetch,
   output logic              prediction_out,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic              upd_predicted,
   output logic              mispredict_out,
   output logic [CNT_W-1:0]  branch_count,
   output logic [CNT_W-1:0]  mispredict_count
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [INDEX_BITS-1:0] fetch_idx;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [1:0]            entry_w [ENTRIES];

   assign fetch_idx = INDEX_BITS'(bht_index(64'(pc_fetch), INDEX_BITS));
   assign upd_idx   = INDEX_BITS'(bht_index(64'(upd_pc), INDEX_BITS));

   // Enables are gated by upd_en first so X on the other update inputs stays harmless.
   for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
      logic hit;
      assign hit = upd_en && (upd_idx == INDEX_BITS'(g));

      sat_counter2 u_cnt (
         .clk   (clk),
         .rst   (rst),
         .inc_i (hit &&  upd_taken),
         .dec_i (hit && !upd_taken),
         .cnt_o (entry_w[g])
      );
   end

   // Reads registered state only: a same-cycle update is seen from the next cycle.
   assign prediction_out = (entry_w[fetch_idx] >= WT);

   logic             mispredict;
   logic             mispredict_q;
   logic             mispredict_d;
   logic [CNT_W-1:0] branch_count_q;
   logic [CNT_W-1:0] branch_count_d;
   logic [CNT_W-1:0] mispredict_count_q;
   logic [CNT_W-1:0] mispredict_count_d;

   assign mispredict = upd_en && (upd_taken ^ upd_predicted);

   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      mispredict_d       = mispredict;
      if (upd_en) begin
         if (branch_count_q != {CNT_W{1'b1}})
            branch_count_d = branch_count_q + CNT_W'(1);
         if (mispredict && (mispredict_count_q != {CNT_W{1'b1}}))
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mispredict_q       <= 1'b0;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         mispredict_q       <= mispredict_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign mispredict_out   = mispredict_q;
   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: constant vector table, random traffic against
// an array model, statistics saturation and asynchronous reset sequences.
module tb_branch_predictor_bht;

   localparam int TB_CNT_W = 8;
   localparam int CMAX     = (1 << TB_CNT_W) - 1;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [31:0]         pc_fetch = '0;
   logic                prediction_out;
   logic                upd_en = 1'b0;
   logic [31:0]         upd_pc = '0;
   logic                upd_taken = 1'b0;
   logic                upd_predicted = 1'b0;
   logic                mispredict_out;
   logic [TB_CNT_W-1:0] branch_count;
   logic [TB_CNT_W-1:0] mispredict_count;

   branch_predictor_bht #(.INDEX_BITS(6), .ADDR_W(32), .CNT_W(TB_CNT_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .pc_fetch         (pc_fetch),
      .prediction_out   (prediction_out),
      .upd_en           (upd_en),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_predicted    (upd_predicted),
      .mispredict_out   (mispredict_out),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: one integer 0..3 per table slot, plain integer statistics.
   int tbl [64];
   int m_bc;
   int m_mc;
   int m_mp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int slot(input logic [31:0] pc);
      return int'((pc / 4) % 64);
   endfunction

   function automatic logic model_pred(input logic [31:0] pc);
      return (tbl[slot(pc)] >= 2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) tbl[i] = 1;
      m_bc = 0;
      m_mc = 0;
      m_mp = 0;
   endtask

   task automatic model_update(input logic en, input logic [31:0] pc, input logic t, input logic p);
      m_mp = 0;
      if (en === 1'b1) begin
         if (t) tbl[slot(pc)] = (tbl[slot(pc)] == 3) ? 3 : tbl[slot(pc)] + 1;
         else   tbl[slot(pc)] = (tbl[slot(pc)] == 0) ? 0 : tbl[slot(pc)] - 1;
         if (m_bc < CMAX) m_bc++;
         if (t != p) begin
            m_mp = 1;
            if (m_mc < CMAX) m_mc++;
         end
      end
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #2 rst = 1'b1;
      upd_en = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
   endtask

   // One cycle against the model: lookup checked before the edge, state after it.
   task automatic cycle(input logic en, input logic [31:0] upc, input logic t,
                        input logic p, input logic [31:0] fpc);
      upd_en = en;  upd_pc = upc;  upd_taken = t;  upd_predicted = p;  pc_fetch = fpc;
      #1 check("prediction", 32'(prediction_out), 32'(model_pred(fpc)));
      @(posedge clk);
      model_update(en, upc, t, p);
      #1;
      check("mispredict_out", 32'(mispredict_out), 32'(m_mp));
      check("branch_count", 32'(branch_count), 32'(m_bc));
      check("mispredict_count", 32'(mispredict_count), 32'(m_mc));
   endtask

   typedef struct {
      logic        en;
      logic [31:0] upc;
      logic        t;
      logic        p;
      logic [31:0] fpc;
      logic        exp_pred;
      logic        exp_mp;
      logic [7:0]  exp_bc;
      logic [7:0]  exp_mc;
   } vec_t;

   vec_t vecs [12];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h40,  1'b0, 1'b0, 8'd0, 8'd0};
      vecs[1]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h40,  1'b0, 1'b1, 8'd1, 8'd1};
      vecs[2]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h40,  1'b1, 1'b1, 8'd2, 8'd2};
      vecs[3]  = '{1'b1, 32'h40, 1'b1, 1'b1, 32'h40,  1'b1, 1'b0, 8'd3, 8'd2};
      vecs[4]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h40,  1'b1, 1'b1, 8'd4, 8'd3};
      vecs[5]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h40,  1'b1, 1'b0, 8'd4, 8'd3};
      vecs[6]  = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 8'd5, 8'd4};
      vecs[7]  = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h0,  1'b1, 1'b0, 8'd6, 8'd4};
      vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 8'd6, 8'd4};
      vecs[9]  = '{1'b1, 32'h8,  1'b1, 1'b0, 32'h8,   1'b0, 1'b1, 8'd7, 8'd5};
      vecs[10] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h8,   1'b1, 1'b0, 8'd7, 8'd5};
      vecs[11] = '{1'b0, 32'hxxxxxxxx, 1'bx, 1'bx, 32'h8, 1'b1, 1'b0, 8'd7, 8'd5};

      // Reset state: every index predicts not-taken, statistics clear.
      reset_dut();
      for (int i = 0; i < 64; i++) begin
         pc_fetch = 32'(i * 4);
         #1 check("reset_sweep_pred", 32'(prediction_out), 32'd0);
      end
      check("reset_bc", 32'(branch_count), 32'd0);
      check("reset_mc", 32'(mispredict_count), 32'd0);
      check("reset_mp", 32'(mispredict_out), 32'd0);

      // Directed table: training, saturation at 11, aliasing, same-cycle update, X inputs.
      for (int i = 0; i < 12; i++) begin
         upd_en = vecs[i].en;  upd_pc = vecs[i].upc;  upd_taken = vecs[i].t;
         upd_predicted = vecs[i].p;  pc_fetch = vecs[i].fpc;
         #1 check($sformatf("vec%0d_pred", i), 32'(prediction_out), 32'(vecs[i].exp_pred));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_mp", i), 32'(mispredict_out), 32'(vecs[i].exp_mp));
         check($sformatf("vec%0d_bc", i), 32'(branch_count), 32'(vecs[i].exp_bc));
         check($sformatf("vec%0d_mc", i), 32'(mispredict_count), 32'(vecs[i].exp_mc));
      end

      // Random traffic on a narrow PC range so entries collide and alias.
      reset_dut();
      for (int n = 0; n < 400; n++) begin
         logic [31:0] upc;
         logic [31:0] fpc;
         logic        t;
         logic        p;
         upc = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
         fpc = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
         t   = ($urandom_range(0, 99) < 70);
         p   = $urandom_range(0, 1) ? model_pred(upc) : 1'($urandom_range(0, 1));
         cycle(1'($urandom_range(0, 1)), upc, t, p, fpc);
      end

      // Statistics saturation: climb to all-ones minus one, then two more mispredicts.
      reset_dut();
      for (int n = 0; n < CMAX - 1; n++) cycle(1'b1, 32'h10, 1'b1, 1'b0, 32'h10);
      check("sat_pre_bc", 32'(branch_count), 32'(CMAX - 1));
      check("sat_pre_mc", 32'(mispredict_count), 32'(CMAX - 1));
      cycle(1'b1, 32'h14, 1'b0, 1'b1, 32'h14);
      check("sat_mp_pulse1", 32'(mispredict_out), 32'd1);
      cycle(1'b1, 32'h14, 1'b1, 1'b0, 32'h14);
      check("sat_mp_pulse2", 32'(mispredict_out), 32'd1);
      check("sat_bc", 32'(branch_count), 32'(CMAX));
      check("sat_mc", 32'(mispredict_count), 32'(CMAX));
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h14);
      check("sat_mp_drop", 32'(mispredict_out), 32'd0);
      check("sat_hold_bc", 32'(branch_count), 32'(CMAX));

      // Asynchronous reset between edges after training 0x40 to strongly taken.
      reset_dut();
      cycle(1'b1, 32'h40, 1'b1, 1'b0, 32'h40);
      cycle(1'b1, 32'h40, 1'b1, 1'b1, 32'h40);
      cycle(1'b1, 32'h4,  1'b1, 1'b0, 32'h40);
      upd_en = 1'b1;  upd_pc = 32'h48;  upd_taken = 1'b1;  upd_predicted = 1'b0;
      pc_fetch = 32'h40;
      #1 check("arst_pre_pred", 32'(prediction_out), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_pred", 32'(prediction_out), 32'd0);
      check("arst_mp", 32'(mispredict_out), 32'd0);
      check("arst_bc", 32'(branch_count), 32'd0);
      check("arst_mc", 32'(mispredict_count), 32'd0);
      @(posedge clk);
      #1;
      check("arst_upd_ignored_bc", 32'(branch_count), 32'd0);
      check("arst_upd_ignored_mp", 32'(mispredict_out), 32'd0);
      upd_en = 1'b0;
      #2 rst = 1'b0;
      model_reset();
      pc_fetch = 32'h48;
      #1 check("arst_upd_ignored_pred", 32'(prediction_out), 32'd0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
